// File: rtl/bank_cmd_issuer.sv
// Per-bank command issuer: a small FIFO that offers buffered commands to the bank FSM
// over a valid/busy handshake. It also flags a starved head and counts issued reads and writes.
module bank_cmd_issuer #(
  parameter int DEPTH      = 4,
  parameter int CMD_W      = 8,
  parameter int RW_BIT     = 0,
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [CMD_W-1:0]         req_cmd,
  output logic                     req_ready,
  input  logic                     flush,
  input  logic                     stall,
  output logic                     valid,
  output logic [CMD_W-1:0]         command,
  input  logic                     ba_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     starve,
  output logic [15:0]              rd_cnt,
  output logic [15:0]              wr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

  logic [CMD_W-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;
  logic [15:0]       rd_q, rd_d, wr_q, wr_d;

  logic empty, full, push, pop;

  // The pointer MSB acts as a lap bit, so equal low bits mean either empty or full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign req_ready = !full;
  assign valid     = !empty && !stall && !flush;
  assign command   = mem_q[rptr_q[AW-1:0]];
  assign push      = req_valid && req_ready && !flush;
  assign pop       = valid && !ba_busy;

  assign level  = wptr_q - rptr_q;
  assign starve = starve_q;
  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      wait_d   = '0;
      starve_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
        if (command[RW_BIT]) rd_d = rd_q + 16'd1;
        else                 wr_d = wr_q + 16'd1;
      end
      // Head age: restarts on every retire and whenever nothing is waiting; saturates.
      if (pop || empty)        wait_d = '0;
      else if (wait_q != '1)   wait_d = wait_q + WAIT_W'(1);
      starve_d = (wait_q >= LIMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= req_cmd;
  end

endmodule

// File: tb/tb_bank_cmd_issuer.sv
// Directed bench for bank_cmd_issuer: a queue model predicts valid/ready/level/command every
// cycle, and directed steps cover fill, same-cycle push/pop, starvation, stall, flush and reset.
module tb_bank_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int CMD_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [CMD_W-1:0] req_cmd = '0;
  logic             req_ready;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic             valid;
  logic [CMD_W-1:0] command;
  logic             ba_busy = 1'b0;
  logic [2:0]       level;
  logic             starve;
  logic [15:0]      rd_cnt, wr_cnt;

  int errors = 0;
  int checks = 0;

  logic [CMD_W-1:0] sb_q [$];
  logic [CMD_W-1:0] head;
  logic [15:0]      exp_rd = '0;
  logic [15:0]      exp_wr = '0;
  bit               m_full, m_valid;
  int               n;

  bank_cmd_issuer #(
    .DEPTH(DEPTH), .CMD_W(CMD_W), .RW_BIT(0), .WAIT_W(8), .WAIT_LIMIT(200)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .flush(flush), .stall(stall), .valid(valid), .command(command), .ba_busy(ba_busy),
    .level(level), .starve(starve), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [CMD_W-1:0] c);
    req_valid = 1'b1;
    req_cmd   = c;
    tick();
    req_valid = 1'b0;
  endtask

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so the negedge sees
  // exactly what the coming edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_rd = '0;
      exp_wr = '0;
    end else begin
      m_full  = (sb_q.size() >= DEPTH);
      m_valid = (sb_q.size() != 0) && !stall && !flush;
      check("mon_valid", 32'(valid), 32'(m_valid));
      check("mon_req_ready", 32'(req_ready), 32'(!m_full));
      check("mon_level", 32'(level), 32'(sb_q.size()));
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_valid && !ba_busy) begin
          head = sb_q.pop_front();
          check("mon_command", 32'(command), 32'(head));
          if (head[0]) exp_rd = exp_rd + 16'd1;
          else         exp_wr = exp_wr + 16'd1;
        end
        if (req_valid && !m_full) sb_q.push_back(req_cmd);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back pushes drained one per cycle by an idle bank.
    ba_busy = 1'b0;
    push_one(8'h11);
    check("t1_valid_next_cycle", 32'(valid), 32'd1);
    push_one(8'h20);
    push_one(8'h33);
    tick();
    tick();
    check("t1_level", 32'(level), 32'd0);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd2);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);

    // Fill to DEPTH behind a busy bank; extra requests are refused.
    ba_busy = 1'b1;
    push_one(8'h40);
    push_one(8'h41);
    push_one(8'h42);
    push_one(8'h43);
    push_one(8'h55);
    push_one(8'h57);
    check("t2_full_level", 32'(level), 32'd4);
    check("t2_full_ready", 32'(req_ready), 32'd0);
    ba_busy = 1'b0;
    #1;
    check("t2_ready_in_pop_cycle", 32'(req_ready), 32'd0);
    tick();
    check("t2_ready_after_pop", 32'(req_ready), 32'd1);
    check("t2_level_after_pop", 32'(level), 32'd3);
    repeat (3) tick();
    check("t2_drained", 32'(level), 32'd0);
    check("t2_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd3);

    // Simultaneous push and pop at level 2.
    ba_busy = 1'b1;
    push_one(8'h60);
    push_one(8'h61);
    check("t3_level_before", 32'(level), 32'd2);
    ba_busy   = 1'b0;
    req_valid = 1'b1;
    req_cmd   = 8'h62;
    tick();
    req_valid = 1'b0;
    check("t3_level_same", 32'(level), 32'd2);
    repeat (2) tick();
    check("t3_drained", 32'(level), 32'd0);

    // Starvation: head stuck behind a busy bank.
    ba_busy = 1'b1;
    push_one(8'h71);
    n = 0;
    while (!starve && n < 300) begin
      tick();
      n++;
    end
    check("t4_starve_edges", 32'(n), 32'd201);
    ba_busy = 1'b0;
    tick();
    check("t4_starve_at_pop_edge", 32'(starve), 32'd1);
    check("t4_level_after_pop", 32'(level), 32'd0);
    tick();
    check("t4_starve_cleared", 32'(starve), 32'd0);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd6);

    // Stall blocks presentation; release resumes pops in the same cycle.
    ba_busy = 1'b1;
    push_one(8'h80);
    push_one(8'h81);
    stall   = 1'b1;
    ba_busy = 1'b0;
    repeat (2) tick();
    check("t5_stall_valid", 32'(valid), 32'd0);
    check("t5_stall_level", 32'(level), 32'd2);
    check("t5_stall_rd", 32'(rd_cnt), 32'd6);
    check("t5_stall_wr", 32'(wr_cnt), 32'd5);
    stall = 1'b0;
    #1;
    check("t5_unstall_valid", 32'(valid), 32'd1);
    tick();
    check("t5_level_1", 32'(level), 32'd1);
    tick();
    check("t5_level_0", 32'(level), 32'd0);

    // Flush beats a concurrent push and would-be pop; counters survive.
    ba_busy = 1'b1;
    push_one(8'h90);
    push_one(8'h91);
    push_one(8'h92);
    check("t6_level_3", 32'(level), 32'd3);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_cmd   = 8'h93;
    ba_busy   = 1'b0;
    #1;
    check("t6_flush_valid", 32'(valid), 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("t6_flush_level", 32'(level), 32'd0);
    check("t6_flush_rd", 32'(rd_cnt), 32'd7);
    check("t6_flush_wr", 32'(wr_cnt), 32'd6);

    // Asynchronous reset mid-stream.
    ba_busy = 1'b1;
    push_one(8'hA1);
    push_one(8'hA2);
    check("t7_level_2", 32'(level), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(valid), 32'd0);
    check("t7_rst_level", 32'(level), 32'd0);
    check("t7_rst_ready", 32'(req_ready), 32'd1);
    check("t7_rst_rd", 32'(rd_cnt), 32'd0);
    tick();
    rst     = 1'b0;
    ba_busy = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
